// File: rtl/pio_in_debounced.sv
// Avalon-MM input PIO: two-flop synchroniser, per-bit debounce, edge capture
// with read/clear, and level- or edge-type interrupt.
module pio_in_debounced #(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned EDGE_TYPE       = 0,
   parameter int unsigned IRQ_TYPE        = 1,
   parameter int unsigned BIT_CLEAR       = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] ADDR_STABLE = 2'd0;
   localparam logic [1:0] ADDR_SYNC   = 2'd1;
   localparam logic [1:0] ADDR_MASK   = 2'd2;
   localparam logic [1:0] ADDR_EDGE   = 2'd3;

   logic [WIDTH-1:0]         meta_q, meta_d;
   logic [WIDTH-1:0]         sync_q, sync_d;
   logic [WIDTH-1:0]         stable_q, stable_d;
   logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]         irq_mask_q, irq_mask_d;
   logic [WIDTH-1:0]         edge_capture_q, edge_capture_d;
   logic [31:0]              readdata_q, readdata_d;

   logic [WIDTH-1:0] rise, fall, edge_evt, clr, rd_sel, irq_src;
   logic             wr_en;
   logic             wd_unused;

   // Synchroniser, debounce counters, register updates and read mux
   always_comb begin
      meta_d         = in_port;
      sync_d         = meta_q;
      stable_d       = stable_q;
      cnt_d          = cnt_q;
      irq_mask_d     = irq_mask_q;
      clr            = '0;
      rd_sel         = '0;
      edge_evt       = '0;
      wr_en          = chipselect & ~write_n;

      for (int i = 0; i < int'(WIDTH); i++) begin
         if (sync_q[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            stable_d[i] = sync_q[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end

      rise = stable_d & ~stable_q;
      fall = ~stable_d & stable_q;
      case (EDGE_TYPE)
         0:       edge_evt = rise;
         1:       edge_evt = fall;
         default: edge_evt = rise | fall;
      endcase

      if (wr_en && address == ADDR_MASK) begin
         irq_mask_d = writedata[WIDTH-1:0];
      end
      if (wr_en && address == ADDR_EDGE) begin
         clr = (BIT_CLEAR != 0) ? writedata[WIDTH-1:0] : '1;
      end
      // Set has priority over clear so an event coinciding with a clear survives
      edge_capture_d = (edge_capture_q & ~clr) | edge_evt;

      // Mux post-edge values so a read reflects the registers as updated at that edge
      case (address)
         ADDR_STABLE: rd_sel = stable_d;
         ADDR_SYNC:   rd_sel = sync_d;
         ADDR_MASK:   rd_sel = irq_mask_d;
         default:     rd_sel = edge_capture_d;
      endcase
      readdata_d = 32'(rd_sel);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q         <= '0;
         sync_q         <= '0;
         stable_q       <= '0;
         cnt_q          <= '0;
         irq_mask_q     <= '0;
         edge_capture_q <= '0;
         readdata_q     <= '0;
      end else begin
         meta_q         <= meta_d;
         sync_q         <= sync_d;
         stable_q       <= stable_d;
         cnt_q          <= cnt_d;
         irq_mask_q     <= irq_mask_d;
         edge_capture_q <= edge_capture_d;
         readdata_q     <= readdata_d;
      end
   end

   assign irq_src   = (IRQ_TYPE == 0) ? stable_q : edge_capture_q;
   assign irq       = |(irq_src & irq_mask_q);
   assign readdata  = readdata_q;
   assign wd_unused = ^writedata;

endmodule

// File: tb/tb_pio_in_debounced.sv
// Bench for pio_in_debounced: two instances (any-edge/edge-irq/W1C and
// falling-edge/level-irq/clear-all) checked against a cycle model plus directed points.
module tb_pio_in_debounced;

   localparam int DEB = 8;

   typedef struct packed {
      logic [3:0]       s1, s2, stab, mask, cap;
      logic [3:0][3:0]  cnt;
      logic [31:0]      rd;
      logic             irq;
   } mdl_t;

   logic        clk, reset_n;
   logic [1:0]  addr_a, addr_b;
   logic        cs_a, cs_b, write_n;
   logic [31:0] writedata;
   logic [31:0] rd_a, rd_b;
   logic [3:0]  in_port;
   logic        irq_a, irq_b;

   int checks = 0;
   int failures = 0;
   mdl_t ma, mb;
   logic [65:0] exp_q[$];

   pio_in_debounced #(.WIDTH(4), .DEBOUNCE_CYCLES(DEB), .EDGE_TYPE(2), .IRQ_TYPE(1),
                      .BIT_CLEAR(1)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .address(addr_a), .chipselect(cs_a),
      .write_n(write_n), .writedata(writedata), .readdata(rd_a),
      .in_port(in_port), .irq(irq_a));

   pio_in_debounced #(.WIDTH(4), .DEBOUNCE_CYCLES(DEB), .EDGE_TYPE(1), .IRQ_TYPE(0),
                      .BIT_CLEAR(0)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .address(addr_b), .chipselect(cs_b),
      .write_n(write_n), .writedata(writedata), .readdata(rd_b),
      .in_port(in_port), .irq(irq_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference behaviour for one instance, one clock edge
   function automatic mdl_t mdl_step(input mdl_t m, input int et, input int it, input int bc,
                                     input logic [3:0] din, input logic [1:0] a,
                                     input logic we, input logic [31:0] wd);
      mdl_t n;
      logic [3:0] ev, clr, src;
      n   = m;
      ev  = '0;
      clr = '0;
      n.s1 = din;
      n.s2 = m.s1;
      for (int i = 0; i < 4; i++) begin
         if (m.s2[i] == m.stab[i]) begin
            n.cnt[i] = '0;
         end else if (int'(m.cnt[i]) == DEB - 1) begin
            n.stab[i] = m.s2[i];
            n.cnt[i]  = '0;
            ev[i] = (et == 2) || (et == 0 && m.s2[i]) || (et == 1 && !m.s2[i]);
         end else begin
            n.cnt[i] = m.cnt[i] + 4'd1;
         end
      end
      if (we && a == 2'd2) n.mask = wd[3:0];
      if (we && a == 2'd3) clr = (bc != 0) ? wd[3:0] : 4'hF;
      n.cap = (m.cap & ~clr) | ev;
      case (a)
         2'd0:    n.rd = {28'd0, n.stab};
         2'd1:    n.rd = {28'd0, n.s2};
         2'd2:    n.rd = {28'd0, n.mask};
         default: n.rd = {28'd0, n.cap};
      endcase
      src   = (it == 0) ? n.stab : n.cap;
      n.irq = |(src & n.mask);
      return n;
   endfunction

   task automatic tick();
      mdl_t na, nb;
      logic [65:0] e;
      na = mdl_step(ma, 2, 1, 1, in_port, addr_a, cs_a && !write_n, writedata);
      nb = mdl_step(mb, 1, 0, 0, in_port, addr_b, cs_b && !write_n, writedata);
      exp_q.push_back({na.rd, na.irq, nb.rd, nb.irq});
      @(posedge clk);
      #1;
      ma = na;
      mb = nb;
      e = exp_q.pop_front();
      check_eq("sb_rd_a", rd_a, e[65:34]);
      check_eq("sb_irq_a", 32'(irq_a), 32'(e[33]));
      check_eq("sb_rd_b", rd_b, e[32:1]);
      check_eq("sb_irq_b", 32'(irq_b), 32'(e[0]));
   endtask

   task automatic bus_wr(input logic sel_a, input logic sel_b, input logic [1:0] a,
                         input logic [31:0] d);
      addr_a    = a;
      addr_b    = a;
      cs_a      = sel_a;
      cs_b      = sel_b;
      write_n   = 1'b0;
      writedata = d;
      tick();
      cs_a      = 1'b0;
      cs_b      = 1'b0;
      write_n   = 1'b1;
      writedata = '0;
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_rd_a"}, rd_a, 32'd0);
      check_eq({tag, "_irq_a"}, 32'(irq_a), 32'd0);
      check_eq({tag, "_rd_b"}, rd_b, 32'd0);
      check_eq({tag, "_irq_b"}, 32'(irq_b), 32'd0);
      ma = '0;
      mb = '0;
      exp_q.delete();
   endtask

   initial begin
      int first;
      reset_n = 1'b0; addr_a = 2'd0; addr_b = 2'd0; cs_a = 1'b0; cs_b = 1'b0;
      write_n = 1'b1; writedata = '0; in_port = 4'h0;
      #3;
      check_reset_state("rst");
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Debounce latency on bit 0
      in_port = 4'b0001; addr_a = 2'd0; addr_b = 2'd1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 1)  check_eq("sync_e1", rd_b, 32'd0);
         if (k == 2)  check_eq("sync_e2", rd_b, 32'd1);
         if (k == 9)  check_eq("stable_e9", rd_a, 32'd0);
         if (k == 10) check_eq("stable_e10", rd_a, 32'd1);
      end
      addr_a = 2'd3; addr_b = 2'd3;
      tick();
      check_eq("cap_rise_a", rd_a, 32'd1);
      check_eq("cap_rise_b", rd_b, 32'd0);

      // Bounce rejection on bit 1, edge irq with mask 0x2
      bus_wr(1'b1, 1'b1, 2'd2, 32'h2);
      bus_wr(1'b1, 1'b0, 2'd3, 32'hF);
      addr_a = 2'd0;
      in_port[1] = 1'b1;
      for (int k = 0; k < 7; k++) tick();
      in_port[1] = 1'b0;
      tick();
      in_port[1] = 1'b1;
      first = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (first == 0 && rd_a[1]) first = k;
      end
      check_eq("bounce_latency", 32'(first), 32'd10);
      addr_a = 2'd3;
      tick();
      check_eq("bounce_cap", rd_a, 32'h2);
      check_eq("irq_edge_a", 32'(irq_a), 32'd1);
      check_eq("irq_level_b", 32'(irq_b), 32'd1);
      bus_wr(1'b1, 1'b0, 2'd3, 32'h2);
      check_eq("irq_after_clr", 32'(irq_a), 32'd0);

      // Bit 0 event is masked off
      in_port[0] = 1'b0;
      for (int k = 0; k < 12; k++) tick();
      check_eq("irq_masked_b0", 32'(irq_a), 32'd0);
      check_eq("cap_b0_fall", rd_a, 32'h1);
      bus_wr(1'b1, 1'b0, 2'd3, 32'hF);

      // Edge modes on bit 2
      bus_wr(1'b0, 1'b1, 2'd3, 32'h0);
      in_port[2] = 1'b1;
      for (int k = 0; k < 12; k++) tick();
      check_eq("em_rise_a", rd_a, 32'h4);
      check_eq("em_rise_b", rd_b, 32'h0);
      bus_wr(1'b1, 1'b0, 2'd3, 32'h4);
      in_port[2] = 1'b0;
      for (int k = 0; k < 12; k++) tick();
      check_eq("em_fall_a", rd_a, 32'h4);
      check_eq("em_fall_b", rd_b, 32'h4);

      // Write-1-to-clear versus clear-all
      bus_wr(1'b1, 1'b1, 2'd3, 32'hF);
      in_port = 4'b1101;
      for (int k = 0; k < 12; k++) tick();
      check_eq("bc_full_a", rd_a, 32'hF);
      bus_wr(1'b1, 1'b1, 2'd3, 32'h5);
      check_eq("bc_w1c_a", rd_a, 32'hA);
      check_eq("bc_all_b", rd_b, 32'h0);

      // Clear coinciding with a new edge on bit 0
      bus_wr(1'b1, 1'b0, 2'd3, 32'hF);
      in_port[0] = 1'b0;
      for (int k = 0; k < 9; k++) tick();
      bus_wr(1'b1, 1'b0, 2'd3, 32'h1);
      check_eq("clr_vs_set", rd_a, 32'h1);

      // Reset mid-debounce restarts the full period
      addr_a = 2'd0; addr_b = 2'd0;
      in_port[1] = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      reset_n = 1'b0;
      #1;
      check_reset_state("midrst");
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      first = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (first == 0 && rd_a[3:0] == in_port) first = k;
      end
      check_eq("rst_latency", 32'(first), 32'd10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
